// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor. The carry chain is cut into STAGES
// chunks of CHUNK bits, and each pipeline stage resolves one chunk. The
// not-yet-consumed operand bits and the finished result chunks travel along
// in delay registers. All stages advance together under a valid/ready
// handshake, so a stalled output freezes the whole pipe and bubbles keep
// their slots. The carry, signed-overflow and zero flags are formed in the
// final stage and registered together with the result.
module pipelined_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  // The divisor is guarded so that an illegal STAGES produces the error
  // below rather than a divide-by-zero during elaboration.
  localparam int CHUNK = WIDTH / ((STAGES < 1) ? 1 : STAGES);
  localparam int LAST  = (STAGES < 1) ? 0 : STAGES - 1;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
    $error("pipelined_adder: STAGES must lie in 1..WIDTH and divide WIDTH");
  end

  // Pipeline state. Entry k holds the contents of stage k.
  logic [STAGES-1:0] valid_r;
  logic [STAGES-1:0] carry_r;
  logic [WIDTH-1:0]  p_r   [STAGES];
  logic [WIDTH-1:0]  qe_r  [STAGES];
  logic [WIDTH-1:0]  res_r [STAGES];
  logic              overflow_r;
  logic              zero_r;

  // Stage inputs and next-state values.
  logic [STAGES-1:0] vin_s;
  logic [STAGES-1:0] cin_s;
  logic [STAGES-1:0] cout_s;
  logic [WIDTH-1:0]  p_in_s    [STAGES];
  logic [WIDTH-1:0]  qe_in_s   [STAGES];
  logic [WIDTH-1:0]  res_in_s  [STAGES];
  logic [WIDTH-1:0]  res_nxt_s [STAGES];
  logic              overflow_nxt_s;
  logic              zero_nxt_s;
  logic              advance_s;
  logic              in_ready_s;

  // Handshake: the whole pipe moves unless a valid result is waiting
  // for a consumer that is not ready.
  always_comb begin
    advance_s  = !valid_r[LAST] || out_ready;
    in_ready_s = advance_s && !reset;
  end

  // Chunk adders. Stage 0 is fed from the ports, and later stages are fed
  // from the registers of the stage before them.
  always_comb begin
    logic [CHUNK:0] sum_v;
    sum_v = '0;

    p_in_s[0]   = p;
    qe_in_s[0]  = sub ? ~q : q;
    res_in_s[0] = '0;
    cin_s[0]    = sub;
    vin_s[0]    = in_valid && in_ready_s;
    for (int k = 1; k < STAGES; k++) begin
      p_in_s[k]   = p_r[k-1];
      qe_in_s[k]  = qe_r[k-1];
      res_in_s[k] = res_r[k-1];
      cin_s[k]    = carry_r[k-1];
      vin_s[k]    = valid_r[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      sum_v = {1'b0, p_in_s[k][k*CHUNK +: CHUNK]}
            + {1'b0, qe_in_s[k][k*CHUNK +: CHUNK]}
            + {{CHUNK{1'b0}}, cin_s[k]};
      res_nxt_s[k]                  = res_in_s[k];
      res_nxt_s[k][k*CHUNK +: CHUNK] = sum_v[CHUNK-1:0];
      cout_s[k]                     = sum_v[CHUNK];
    end

    // Signed overflow occurs when the operands share a sign and the result
    // has the other sign.
    overflow_nxt_s = (p_in_s[LAST][WIDTH-1] == qe_in_s[LAST][WIDTH-1])
                  && (res_nxt_s[LAST][WIDTH-1] != p_in_s[LAST][WIDTH-1]);
    zero_nxt_s     = (res_nxt_s[LAST] == {WIDTH{1'b0}});
  end

  // Pipeline registers. Every stage loads together on advance and holds
  // otherwise. Reset drops every in-flight beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_r[k] <= 1'b0;
        carry_r[k] <= 1'b0;
        p_r[k]     <= '0;
        qe_r[k]    <= '0;
        res_r[k]   <= '0;
      end
      overflow_r <= 1'b0;
      zero_r     <= 1'b0;
    end else if (advance_s) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_r[k] <= vin_s[k];
        carry_r[k] <= cout_s[k];
        p_r[k]     <= p_in_s[k];
        qe_r[k]    <= qe_in_s[k];
        res_r[k]   <= res_nxt_s[k];
      end
      overflow_r <= overflow_nxt_s;
      zero_r     <= zero_nxt_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = valid_r[LAST];
  assign out       = res_r[LAST];
  assign carry_out = carry_r[LAST];
  assign overflow  = overflow_r;
  assign zero      = zero_r;

endmodule
